// File: rtl/pwm_sequencer_pkg.sv
// Shared definitions for the ThreePhasePWM run controller: state encoding,
// duty width and default sequencing constants.
package pwm_sequencer_pkg;

   localparam int DUTY_W         = 8;
   localparam int STEP_DEF       = 4;
   localparam int RAMP_DIV_DEF   = 64;
   localparam int ARM_CYCLES_DEF = 180;

   // 3-bit encoding is also what status/register blocks decode.
   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_ARM       = 3'd1,
      ST_RAMP      = 3'd2,
      ST_RUN       = 3'd3,
      ST_RAMP_DOWN = 3'd4,
      ST_FAULT     = 3'd5
   } pwm_state_e;

   // Bits needed for a counter spanning 0..n-1 (at least one bit).
   function automatic int cnt_width(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/pwm_sequencer_duty_slew.sv
// Ramp-tick prescaler plus a saturating one-step move of the duty toward a
// goal. Shared by the soft-start/slew ramp and the controlled ramp-down.
module duty_slew
   import pwm_sequencer_pkg::*;
#(
   parameter int             DW       = DUTY_W,
   parameter logic [DW-1:0]  STEP     = DW'(STEP_DEF),
   parameter int             RAMP_DIV = RAMP_DIV_DEF
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [DW-1:0] cur,
   input  logic [DW-1:0] goal,
   input  logic          tick_en,
   input  logic          clr,
   output logic [DW-1:0] nxt,
   output logic          done
);

   localparam int            PW       = cnt_width(RAMP_DIV);
   localparam logic [PW-1:0] PRE_LAST = PW'(RAMP_DIV - 1);

   logic [PW-1:0] pre_cnt;
   logic          tick;

   // One step toward goal, evaluated two bits wider so neither direction can
   // wrap; the result is clamped at the goal so it never overshoots.
   function automatic logic [DW-1:0] step_toward(input logic [DW-1:0] c_in,
                                                 input logic [DW-1:0] g_in);
      logic signed [DW+1:0] c;
      logic signed [DW+1:0] g;
      logic signed [DW+1:0] s;
      logic signed [DW+1:0] r;
      c = $signed({2'b00, c_in});
      g = $signed({2'b00, g_in});
      s = $signed({2'b00, STEP});
      if (c < g) begin
         r = c + s;
         return (r > g) ? g_in : r[DW-1:0];
      end else if (c > g) begin
         r = c - s;
         return (r < g) ? g_in : r[DW-1:0];
      end
      return c_in;
   endfunction

   assign tick = tick_en && (pre_cnt == PRE_LAST);

   // Stepped duty on a ramp tick, otherwise hold; done once the goal is met.
   always_comb begin
      nxt  = tick ? step_toward(cur, goal) : cur;
      done = (nxt == goal);
   end

   // Prescaler: wraps every RAMP_DIV enabled clocks, cleared on state change.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pre_cnt <= '0;
      end else if (clr) begin
         pre_cnt <= '0;
      end else if (tick_en) begin
         pre_cnt <= tick ? '0 : pre_cnt + PW'(1);
      end
   end

endmodule

// File: rtl/pwm_sequencer.sv
// Run controller for ThreePhasePWM: arm, soft-start ramp, run with slewed
// target changes, controlled ramp-down and latched fault shutdown.
module pwm_sequencer
   import pwm_sequencer_pkg::*;
#(
   parameter int             DW         = DUTY_W,
   parameter logic [DW-1:0]  STEP       = DW'(STEP_DEF),
   parameter int             RAMP_DIV   = RAMP_DIV_DEF,
   parameter int             ARM_CYCLES = ARM_CYCLES_DEF
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic          stop,
   input  logic          fault,
   input  logic          fault_clear,
   input  logic [DW-1:0] target_duty,
   output logic          pwm_en,
   output logic [DW-1:0] duty_cycle,
   output logic [2:0]    state_o,
   output logic          at_target,
   output logic          fault_latched
);

   localparam int            AW       = cnt_width(ARM_CYCLES);
   localparam logic [AW-1:0] ARM_LAST = AW'(ARM_CYCLES - 1);

   pwm_state_e    state_q;
   pwm_state_e    state_d;
   logic [DW-1:0] duty_d;
   logic [AW-1:0] arm_cnt;
   logic [DW-1:0] slew_goal;
   logic [DW-1:0] slew_nxt;
   logic          slew_done;
   logic          slew_tick_en;
   logic          state_chg;

   assign state_chg    = (state_d != state_q);
   assign slew_tick_en = (state_q == ST_RAMP) || (state_q == ST_RAMP_DOWN);
   // Ramp-down always heads for zero; the live target is ignored there.
   assign slew_goal    = (state_q == ST_RAMP_DOWN) ? '0 : target_duty;
   assign state_o      = state_q;

   duty_slew #(
      .DW       (DW),
      .STEP     (STEP),
      .RAMP_DIV (RAMP_DIV)
   ) u_slew (
      .clk     (clk),
      .rst     (rst),
      .cur     (duty_cycle),
      .goal    (slew_goal),
      .tick_en (slew_tick_en),
      .clr     (state_chg),
      .nxt     (slew_nxt),
      .done    (slew_done)
   );

   // Next-state and next-duty decode; fault outranks stop, stop outranks start.
   always_comb begin
      state_d = state_q;
      duty_d  = duty_cycle;
      if (fault) begin
         state_d = ST_FAULT;
         duty_d  = '0;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               duty_d = '0;
               if (start && !stop) state_d = ST_ARM;
            end
            ST_ARM: begin
               if (stop)                     state_d = ST_RAMP_DOWN;
               else if (arm_cnt == ARM_LAST) state_d = ST_RAMP;
            end
            ST_RAMP: begin
               if (stop) begin
                  state_d = ST_RAMP_DOWN;
               end else begin
                  duty_d = slew_nxt;
                  if (slew_done) state_d = ST_RUN;
               end
            end
            ST_RUN: begin
               if (stop)                           state_d = ST_RAMP_DOWN;
               else if (target_duty != duty_cycle) state_d = ST_RAMP;
            end
            ST_RAMP_DOWN: begin
               duty_d = slew_nxt;
               if (slew_done) state_d = ST_IDLE;
            end
            ST_FAULT: begin
               duty_d = '0;
               if (fault_clear) state_d = ST_IDLE;
            end
            default: begin
               state_d = ST_IDLE;
               duty_d  = '0;
            end
         endcase
      end
   end

   // State register and registered outputs, all derived from the next state.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q       <= ST_IDLE;
         pwm_en        <= 1'b0;
         duty_cycle    <= '0;
         at_target     <= 1'b0;
         fault_latched <= 1'b0;
      end else begin
         state_q       <= state_d;
         pwm_en        <= (state_d == ST_ARM) || (state_d == ST_RAMP) ||
                          (state_d == ST_RUN) || (state_d == ST_RAMP_DOWN);
         duty_cycle    <= duty_d;
         at_target     <= (state_d == ST_RUN);
         fault_latched <= (state_d == ST_FAULT);
      end
   end

   // Arm dwell counter: runs only in ARM, cleared on every state change.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         arm_cnt <= '0;
      end else if (state_chg) begin
         arm_cnt <= '0;
      end else if (state_q == ST_ARM) begin
         arm_cnt <= arm_cnt + AW'(1);
      end
   end

endmodule

// File: tb/tb_pwm_sequencer.sv
// Directed bench for pwm_sequencer with STEP=16, RAMP_DIV=4, ARM_CYCLES=8.
module tb_pwm_sequencer;

   logic       clk;
   logic       rst;
   logic       start;
   logic       stop;
   logic       fault;
   logic       fault_clear;
   logic [7:0] target_duty;
   logic       pwm_en;
   logic [7:0] duty_cycle;
   logic [2:0] state_o;
   logic       at_target;
   logic       fault_latched;

   int checks = 0;
   int errors = 0;

   pwm_sequencer #(
      .DW         (8),
      .STEP       (8'd16),
      .RAMP_DIV   (4),
      .ARM_CYCLES (8)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .start         (start),
      .stop          (stop),
      .fault         (fault),
      .fault_clear   (fault_clear),
      .target_duty   (target_duty),
      .pwm_en        (pwm_en),
      .duty_cycle    (duty_cycle),
      .state_o       (state_o),
      .at_target     (at_target),
      .fault_latched (fault_latched)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got timeout want finish");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      rst = 1'b0; start = 1'b0; stop = 1'b0; fault = 1'b0; fault_clear = 1'b0;
      tick();
      tick();
      rst = 1'b1;
   endtask

   // Reset, start toward tgt and wait (bounded) for RUN.
   task automatic bring_up(input logic [7:0] tgt);
      apply_reset();
      target_duty = tgt;
      start = 1'b1; tick(); start = 1'b0;
      for (int i = 0; i < 200 && state_o != 3'd3; i++) tick();
      checks++;
      if (state_o !== 3'd3) begin
         errors++; $display("FAIL bring_up_run got %0d want 3", state_o);
      end
   endtask

   task automatic test_reset();
      rst = 1'b0; start = 1'b0; stop = 1'b0; fault = 1'b0; fault_clear = 1'b0;
      target_duty = 8'd0;
      tick();
      checks++; if (state_o !== 3'd0) begin errors++; $display("FAIL rst_state got %0d want 0", state_o); end
      checks++; if (pwm_en !== 1'b0) begin errors++; $display("FAIL rst_pwm_en got %0b want 0", pwm_en); end
      checks++; if (duty_cycle !== 8'd0) begin errors++; $display("FAIL rst_duty got %0d want 0", duty_cycle); end
      checks++; if (at_target !== 1'b0) begin errors++; $display("FAIL rst_at_target got %0b want 0", at_target); end
      checks++; if (fault_latched !== 1'b0) begin errors++; $display("FAIL rst_fault_latched got %0b want 0", fault_latched); end
      rst = 1'b1;
   endtask

   task automatic test_start_ramp();
      apply_reset();
      target_duty = 8'd64;
      start = 1'b1; tick(); start = 1'b0;
      checks++; if (state_o !== 3'd1 || pwm_en !== 1'b1 || duty_cycle !== 8'd0) begin
         errors++; $display("FAIL arm_entry got st=%0d en=%0b duty=%0d want st=1 en=1 duty=0", state_o, pwm_en, duty_cycle);
      end
      for (int i = 1; i < 8; i++) begin
         tick();
         checks++; if (state_o !== 3'd1 || duty_cycle !== 8'd0) begin
            errors++; $display("FAIL arm_hold got st=%0d duty=%0d want st=1 duty=0", state_o, duty_cycle);
         end
      end
      tick();
      checks++; if (state_o !== 3'd2 || duty_cycle !== 8'd0) begin
         errors++; $display("FAIL ramp_entry got st=%0d duty=%0d want st=2 duty=0", state_o, duty_cycle);
      end
      for (int k = 1; k <= 4; k++) begin
         repeat (3) begin
            tick();
            checks++; if (duty_cycle !== 8'(16 * (k - 1))) begin
               errors++; $display("FAIL ramp_hold got %0d want %0d", duty_cycle, 16 * (k - 1));
            end
         end
         tick();
         checks++; if (duty_cycle !== 8'(16 * k)) begin
            errors++; $display("FAIL ramp_step got %0d want %0d", duty_cycle, 16 * k);
         end
         checks++; if (state_o !== ((k == 4) ? 3'd3 : 3'd2) || at_target !== (k == 4)) begin
            errors++; $display("FAIL ramp_state got st=%0d at=%0b want st=%0d at=%0b", state_o, at_target, (k == 4) ? 3 : 2, k == 4);
         end
      end
   endtask

   task automatic test_non_multiple();
      int exp_seq [5] = '{16, 32, 48, 64, 70};
      apply_reset();
      target_duty = 8'd70;
      start = 1'b1; tick(); start = 1'b0;
      repeat (8) tick();
      for (int k = 0; k < 5; k++) begin
         repeat (4) tick();
         checks++; if (duty_cycle !== 8'(exp_seq[k])) begin
            errors++; $display("FAIL clamp_step got %0d want %0d", duty_cycle, exp_seq[k]);
         end
      end
      checks++; if (state_o !== 3'd3 || at_target !== 1'b1) begin
         errors++; $display("FAIL clamp_run got st=%0d at=%0b want st=3 at=1", state_o, at_target);
      end
   endtask

   task automatic test_slew_down();
      bring_up(8'd64);
      target_duty = 8'd40;
      tick();
      checks++; if (state_o !== 3'd2 || at_target !== 1'b0 || duty_cycle !== 8'd64) begin
         errors++; $display("FAIL slew_entry got st=%0d at=%0b duty=%0d want st=2 at=0 duty=64", state_o, at_target, duty_cycle);
      end
      repeat (3) tick();
      checks++; if (duty_cycle !== 8'd64) begin errors++; $display("FAIL slew_hold got %0d want 64", duty_cycle); end
      tick();
      checks++; if (duty_cycle !== 8'd48 || state_o !== 3'd2) begin
         errors++; $display("FAIL slew_step1 got st=%0d duty=%0d want st=2 duty=48", state_o, duty_cycle);
      end
      repeat (4) tick();
      checks++; if (duty_cycle !== 8'd40 || state_o !== 3'd3 || at_target !== 1'b1) begin
         errors++; $display("FAIL slew_step2 got st=%0d duty=%0d at=%0b want st=3 duty=40 at=1", state_o, duty_cycle, at_target);
      end
   endtask

   task automatic test_stop();
      bring_up(8'd64);
      stop = 1'b1; tick(); stop = 1'b0;
      checks++; if (state_o !== 3'd4 || pwm_en !== 1'b1 || duty_cycle !== 8'd64) begin
         errors++; $display("FAIL stop_entry got st=%0d en=%0b duty=%0d want st=4 en=1 duty=64", state_o, pwm_en, duty_cycle);
      end
      for (int k = 1; k <= 4; k++) begin
         repeat (3) tick();
         checks++; if (duty_cycle !== 8'(64 - 16 * (k - 1))) begin
            errors++; $display("FAIL down_hold got %0d want %0d", duty_cycle, 64 - 16 * (k - 1));
         end
         tick();
         checks++; if (duty_cycle !== 8'(64 - 16 * k)) begin
            errors++; $display("FAIL down_step got %0d want %0d", duty_cycle, 64 - 16 * k);
         end
         checks++; if (state_o !== ((k == 4) ? 3'd0 : 3'd4) || pwm_en !== (k != 4)) begin
            errors++; $display("FAIL down_state got st=%0d en=%0b want st=%0d en=%0b", state_o, pwm_en, (k == 4) ? 0 : 4, k != 4);
         end
      end
   endtask

   task automatic test_fault();
      apply_reset();
      target_duty = 8'd64;
      start = 1'b1; tick(); start = 1'b0;
      for (int i = 0; i < 100 && duty_cycle != 8'd48; i++) tick();
      checks++; if (duty_cycle !== 8'd48) begin errors++; $display("FAIL fault_setup got %0d want 48", duty_cycle); end
      fault = 1'b1; tick();
      checks++; if (state_o !== 3'd5 || pwm_en !== 1'b0 || duty_cycle !== 8'd0 || fault_latched !== 1'b1) begin
         errors++; $display("FAIL fault_entry got st=%0d en=%0b duty=%0d fl=%0b want st=5 en=0 duty=0 fl=1", state_o, pwm_en, duty_cycle, fault_latched);
      end
      fault_clear = 1'b1; tick(); fault_clear = 1'b0;
      checks++; if (state_o !== 3'd5 || fault_latched !== 1'b1) begin
         errors++; $display("FAIL fault_clear_blocked got st=%0d fl=%0b want st=5 fl=1", state_o, fault_latched);
      end
      fault = 1'b0; start = 1'b1; tick(); start = 1'b0;
      checks++; if (state_o !== 3'd5) begin errors++; $display("FAIL fault_hold got %0d want 5", state_o); end
      fault_clear = 1'b1; tick(); fault_clear = 1'b0;
      checks++; if (state_o !== 3'd0 || fault_latched !== 1'b0) begin
         errors++; $display("FAIL fault_exit got st=%0d fl=%0b want st=0 fl=0", state_o, fault_latched);
      end
      start = 1'b1; tick(); start = 1'b0;
      checks++; if (state_o !== 3'd1 || pwm_en !== 1'b1) begin
         errors++; $display("FAIL fault_restart got st=%0d en=%0b want st=1 en=1", state_o, pwm_en);
      end
   endtask

   task automatic test_priority();
      apply_reset();
      start = 1'b1; stop = 1'b1; fault = 1'b1; tick();
      start = 1'b0; stop = 1'b0;
      checks++; if (state_o !== 3'd5 || fault_latched !== 1'b1 || pwm_en !== 1'b0) begin
         errors++; $display("FAIL prio_fault got st=%0d fl=%0b en=%0b want st=5 fl=1 en=0", state_o, fault_latched, pwm_en);
      end
      fault = 1'b0; fault_clear = 1'b1; tick(); fault_clear = 1'b0;
      stop = 1'b1; tick(); stop = 1'b0;
      checks++; if (state_o !== 3'd0 || pwm_en !== 1'b0) begin
         errors++; $display("FAIL idle_stop got st=%0d en=%0b want st=0 en=0", state_o, pwm_en);
      end
      start = 1'b1; tick(); start = 1'b0;
      stop = 1'b1; tick(); stop = 1'b0;
      checks++; if (state_o !== 3'd4 || pwm_en !== 1'b1 || duty_cycle !== 8'd0) begin
         errors++; $display("FAIL arm_stop got st=%0d en=%0b duty=%0d want st=4 en=1 duty=0", state_o, pwm_en, duty_cycle);
      end
      tick();
      checks++; if (state_o !== 3'd0 || pwm_en !== 1'b0) begin
         errors++; $display("FAIL arm_stop_idle got st=%0d en=%0b want st=0 en=0", state_o, pwm_en);
      end
   endtask

   task automatic test_zero_target();
      apply_reset();
      target_duty = 8'd0;
      start = 1'b1; tick(); start = 1'b0;
      repeat (8) tick();
      checks++; if (state_o !== 3'd2) begin errors++; $display("FAIL zero_ramp got %0d want 2", state_o); end
      tick();
      checks++; if (state_o !== 3'd3 || at_target !== 1'b1 || duty_cycle !== 8'd0) begin
         errors++; $display("FAIL zero_run got st=%0d at=%0b duty=%0d want st=3 at=1 duty=0", state_o, at_target, duty_cycle);
      end
   endtask

   task automatic test_async_reset();
      apply_reset();
      target_duty = 8'd64;
      start = 1'b1; tick(); start = 1'b0;
      for (int i = 0; i < 100 && duty_cycle != 8'd32; i++) tick();
      checks++; if (duty_cycle !== 8'd32 || state_o !== 3'd2) begin
         errors++; $display("FAIL async_setup got st=%0d duty=%0d want st=2 duty=32", state_o, duty_cycle);
      end
      #2;
      rst = 1'b0;
      #1;
      checks++; if (state_o !== 3'd0 || pwm_en !== 1'b0 || duty_cycle !== 8'd0 ||
                    at_target !== 1'b0 || fault_latched !== 1'b0) begin
         errors++; $display("FAIL async_reset got st=%0d en=%0b duty=%0d at=%0b fl=%0b want all 0",
                            state_o, pwm_en, duty_cycle, at_target, fault_latched);
      end
      tick();
      rst = 1'b1;
      tick();
      checks++; if (state_o !== 3'd0 || duty_cycle !== 8'd0) begin
         errors++; $display("FAIL async_release got st=%0d duty=%0d want st=0 duty=0", state_o, duty_cycle);
      end
   endtask

   initial begin
      test_reset();
      test_start_ramp();
      test_non_multiple();
      test_slew_down();
      test_stop();
      test_fault();
      test_priority();
      test_zero_target();
      test_async_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/pwm_sequencer.md
Name: pwm_sequencer

Overview:
- Run controller for the ThreePhasePWM datapath; drives its en and duty_cycle inputs.
- Sequences arm, soft-start ramp, run, slewed target changes, controlled ramp-down and latched fault shutdown.
- Sits between the host/control logic and ThreePhasePWM, in the same clk domain.

Parameters:
- DW, 8, duty width; matches the ThreePhasePWM duty_cycle input.
- STEP, 8'd4, duty increment/decrement per ramp tick; 1..2^DW-1.
- RAMP_DIV, 64, clocks per ramp tick; >=1.
- ARM_CYCLES, 180, clocks in ARM with en=1 and duty=0, so all three phase counters are running before the ramp (phase stagger is about 2*85 clocks).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle request to start; honoured only in IDLE.
- stop  in  1  single-cycle request for controlled shutdown.
- fault  in  1  level-sensitive hardware fault input.
- fault_clear  in  1  single-cycle request to acknowledge a fault.
- target_duty  in  DW  requested duty, sampled live.
- pwm_en  out  1  to ThreePhasePWM en.
- duty_cycle  out  DW  to ThreePhasePWM duty_cycle.
- state_o  out  3  encoded state, for debug.
- at_target  out  1  high when duty_cycle==target_duty in RUN.
- fault_latched  out  1  high while in FAULT.

Behaviour:
- All outputs registered. Reset (rst=0, async) values: state IDLE, pwm_en=0, duty_cycle=0, at_target=0, fault_latched=0, prescaler=0, arm counter=0.
- State encoding: IDLE=0, ARM=1, RAMP=2, RUN=3, RAMP_DOWN=4, FAULT=5.
- Request priority, evaluated each cycle: fault > stop > start.
- IDLE: pwm_en=0, duty=0. start=1 and stop=0 -> ARM next cycle.
- ARM: pwm_en=1, duty=0; arm counter counts 0..ARM_CYCLES-1. Terminal count -> RAMP.
- RAMP: pwm_en=1; prescaler counts 0..RAMP_DIV-1. Each terminal count is one tick:
  - if duty<target: duty=min(duty+STEP, target);
  - if duty>target: duty=max(duty-STEP, target).
  - Compute at DW+1 bits; no wrap-around.
  - Leave for RUN on the clock edge where duty equals target (includes target reached by a tick, and target==duty on entry).
- RUN: at_target=1, duty held. target_duty!=duty -> RAMP next cycle and at_target=0 (slew in either direction).
- RAMP_DOWN: entered from ARM, RAMP or RUN when stop=1.
  - Each tick: duty=max(duty-STEP, 0); target_duty is ignored.
  - duty==0 -> IDLE, with pwm_en=0 from that edge.
  - stop in ARM goes straight to RAMP_DOWN; duty is already 0, so the next cycle is IDLE.
- FAULT:
  - Entered from any state when fault=1, with one-cycle latency.
  - On that edge: pwm_en=0, duty=0, fault_latched=1. There is no ramp-down.
  - Stays in FAULT while fault=1, and ignores start/stop.
  - Exit: fault_clear=1 with fault=0 -> IDLE. fault_clear while fault=1 is ignored.
- Prescaler and arm counter clear on every state change, so the first tick after entering RAMP or RAMP_DOWN comes RAMP_DIV clocks later.
- start outside IDLE, and stop in IDLE or FAULT, are ignored with no side effects.
- Async reset mid-ramp: outputs go to reset values immediately, with no dependence on clk.
- duty_cycle is the raw request. ThreePhasePWM applies its own correction internally; this block does not invert.

Decomposition:
- Shared package holds:
  - the state enum and its 3-bit encoding (shared with any status/register block);
  - DW;
  - default constants for STEP, RAMP_DIV, ARM_CYCLES.
- One sub-module, duty_slew: prescaler plus saturating step toward a goal. It serves both RAMP and RAMP_DOWN.
  - Inputs: cur, goal, tick_en, clr.
  - Outputs: nxt, done.
- The FSM stays in the top module.

Test Plan:
- Bench parameters for all scenarios: STEP=16, RAMP_DIV=4, ARM_CYCLES=8.
- Start ramp: reset, target=64, pulse start -> pwm_en=1 next cycle; duty stays 0 for 8 clocks, then reaches 16/32/48/64 every 4 clocks; RUN with at_target=1 after 16 clocks in RAMP.
- Non-multiple target: target=70 -> duty 16, 32, 48, 64, 70 (clamped, no overshoot), then RUN.
- Slew down: in RUN at 64, set target=40 -> RAMP next cycle; duty goes 48, then 40; back to RUN.
- Stop: in RUN at 64, pulse stop -> RAMP_DOWN; duty goes 48, 32, 16, 0 at 4-clock spacing; IDLE with pwm_en=0 on the same edge duty reaches 0.
- Fault: at duty 48, raise fault -> next edge pwm_en=0, duty=0, fault_latched=1. fault_clear while fault=1 leaves state in FAULT. Drop fault, then pulse fault_clear -> IDLE. start then works normally.
- Priority and reset: start, stop and fault asserted together in IDLE -> FAULT. Separately, assert rst low mid-RAMP, asynchronously between clk edges -> all outputs return to reset values immediately.
